// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: triggered burst capture of wide ADC beats into a local buffer, replayed to the PS as narrow AXIS words
module adc_capture_ctrl #(
  parameter int S_W    = 256,
  parameter int M_W    = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              pl_clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trigger,
  input  logic              abort,
  input  logic [ADDR_W:0]   capture_len,
  input  logic [S_W-1:0]    s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [M_W-1:0]    m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done
);
  localparam int NW = S_W / M_W;
  localparam int WI_W = NW > 1 ? $clog2(NW) : 1;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [WI_W-1:0] WLAST = WI_W'(NW - 1);
  localparam logic [WI_W-1:0] WONE = WI_W'(1);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;
  state_t state, state_nx;
  logic [S_W-1:0] mem [DEPTH];
  logic [S_W-1:0] obuf;
  logic [ADDR_W:0] len, wr_ptr, rd_ptr, len_clamp;
  logic [WI_W-1:0] widx;
  logic ovalid, wr_en, wr_done, ld, hs, beat_end, fin;
  assign len_clamp = (capture_len == '0 || capture_len > FULL) ? FULL : capture_len;
  assign wr_en = !abort && s_axis_tvalid && (state == CAPTURE || (state == ARMED && trigger));
  assign wr_done = wr_en && (wr_ptr + ONE) == len;
  assign hs = ovalid && m_axis_tready;
  assign beat_end = hs && widx == WLAST;
  assign fin = beat_end && rd_ptr == len;
  assign ld = !abort && state == READOUT && rd_ptr != len && (!ovalid || beat_end);
  // state register
  always_ff @(posedge pl_clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next-state: abort wins over everything, arm/trigger only honoured in their own state
  always_comb
    state_nx = abort ? IDLE :
               state == IDLE    ? (arm ? ARMED : IDLE) :
               state == ARMED   ? (trigger ? (wr_done ? READOUT : CAPTURE) : ARMED) :
               state == CAPTURE ? (wr_done ? READOUT : CAPTURE) :
                                  (fin ? IDLE : READOUT);
  // outputs: serialize the held beat, low word first
  always_comb begin
    busy = state != IDLE;
    m_axis_tvalid = ovalid;
    m_axis_tlast = ovalid && widx == WLAST && rd_ptr == len;
    m_axis_tdata = obuf[widx*M_W +: M_W];
  end
  // pointers, word index and handshake bookkeeping; next beat is fetched on the last word's handshake so words flow without bubbles
  always_ff @(posedge pl_clk or negedge rst)
    if (!rst) begin
      {len, wr_ptr, rd_ptr, widx} <= '0;
      {ovalid, done, s_axis_tready} <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      done <= fin && !abort;
      if (state == IDLE && arm && !abort) begin
        len <= len_clamp;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (abort || fin) ovalid <= 1'b0;
      else if (ld) begin
        ovalid <= 1'b1;
        rd_ptr <= rd_ptr + ONE;
        widx <= '0;
      end else if (hs) widx <= widx + WONE;
    end
  // capture buffer with registered read port; contents need no reset
  always_ff @(posedge pl_clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= s_axis_tdata;
    if (ld) obuf <= mem[rd_ptr[ADDR_W-1:0]];
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: randomized bench with a word-queue reference model for adc_capture_ctrl
module tb_adc_capture_ctrl;
  localparam int S_W = 256, M_W = 32, DEPTH = 64, AW = 6, NW = S_W / M_W;
  typedef struct packed {logic [31:0] d; logic l;} word_t;
  logic clk = 0, rst_n = 0, arm = 0, trigger = 0, abort = 0;
  logic [AW:0] capture_len = '0;
  logic [S_W-1:0] s_tdata = '0;
  logic s_tvalid = 0, s_tready;
  logic [M_W-1:0] m_tdata;
  logic m_tvalid, m_tready = 0, m_tlast, busy, done;
  word_t exp_q[$];
  logic [31:0] got[$];
  int vecs = 0, errs = 0, cyc = 0, pops = 0, dones = 0, first_tv = -1, last_cyc = 0, last_idx = -1;
  int rdy_pct = 100;
  bit chk_en = 0, done_due = 0, idle_next = 0, hold_rdy = 0;
  logic [6:0] pat = 7'b1011001;
  always #5 clk = ~clk;
  adc_capture_ctrl #(.S_W(S_W), .M_W(M_W), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .pl_clk(clk), .rst(rst_n), .arm(arm), .trigger(trigger), .abort(abort),
    .capture_len(capture_len), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .busy(busy), .done(done));
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [S_W-1:0] rnd();
    logic [S_W-1:0] r;
    for (int w = 0; w < NW; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // per-cycle compare against the expected word queue
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("done", done, done_due);
      if (done) dones++;
      done_due = 0;
      if (idle_next) begin
        check("abort_tvalid", m_tvalid, 0);
        check("abort_busy", busy, 0);
        idle_next = 0;
      end
      if (abort) begin
        exp_q.delete();
        idle_next = 1;
      end else if (m_tvalid) begin
        if (first_tv < 0) first_tv = cyc;
        if (exp_q.size() == 0) check("unexpected_word", m_tvalid, 0);
        else begin
          check("tdata", m_tdata, exp_q[0].d);
          check("tlast", m_tlast, exp_q[0].l);
          if (m_tready) begin
            got.push_back(m_tdata);
            if (m_tlast) last_idx = got.size() - 1;
            last_cyc = cyc;
            pops++;
            done_due = exp_q[0].l;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end
  // PS-side ready: random with rdy_pct, forced low while an abort is being applied
  initial forever begin
    @(posedge clk);
    #2;
    m_tready = hold_rdy ? 1'b0 : ($urandom_range(99) < rdy_pct);
  end
  task automatic burst(int len_in, int gap, bit pat_mode, bit seq, bit disturb, int abort_after);
    int n, cnt, i, t, d0, cap_end;
    logic [S_W-1:0] b;
    n = (len_in == 0 || len_in > DEPTH) ? DEPTH : len_in;
    cnt = 0; i = 0; t = 0; d0 = dones;
    got.delete(); first_tv = -1; last_idx = -1; pops = 0;
    arm = 1; trigger = $urandom_range(1); capture_len = len_in[AW:0]; s_tvalid = 1; s_tdata = rnd();
    step();
    arm = 0; trigger = 0; capture_len = AW'($urandom);
    repeat ($urandom_range(3)) begin
      s_tvalid = $urandom_range(1); s_tdata = rnd();
      step();
    end
    trigger = 1;
    while (cnt < n && i < 1000) begin
      s_tvalid = pat_mode ? pat[i % 7] : ($urandom_range(99) >= gap);
      b = seq ? {NW{cnt[31:0]}} : rnd();
      s_tdata = s_tvalid ? b : rnd();
      if (s_tvalid) begin
        for (int w = 0; w < NW; w++) exp_q.push_back(word_t'{d: b[w*32 +: 32], l: (cnt == n-1 && w == NW-1)});
        cnt++;
      end
      arm = disturb && i == 1;
      step();
      trigger = trigger & $urandom_range(1);
      arm = 0;
      i++;
    end
    cap_end = cyc;
    trigger = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      s_tvalid = $urandom_range(1); s_tdata = rnd();
      arm = disturb && t == 3; trigger = disturb && t == 3;
      if (abort_after >= 0 && pops >= abort_after) begin
        hold_rdy = 1; abort = 1;
        step();
        abort = 0; hold_rdy = 0;
        step();
        break;
      end
      step();
      arm = 0; trigger = 0; t++;
    end
    arm = 0; trigger = 0; s_tvalid = 0;
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    step(); step();
    check("done_count", dones - d0, abort_after >= 0 ? 0 : 1);
    if (abort_after < 0) check("first_tv_latency", (first_tv - cap_end) <= 3, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    step();
    rst_n = 1;
    step();
    chk_en = 1;
    @(negedge clk);
    check("s_tready_live", s_tready, 1);
    step();
    trigger = 1; s_tvalid = 1; s_tdata = rnd();
    repeat (3) step();
    trigger = 0; s_tvalid = 0;
    @(negedge clk);
    check("idle_trigger_busy", busy, 0);
    check("idle_trigger_tvalid", m_tvalid, 0);
    step();
    rdy_pct = 100;
    burst(4, 20, 0, 1, 0, -1);
    check("t1_count", got.size(), 32);
    check("t1_w0", got[0], 0);
    check("t1_w8", got[8], 1);
    check("t1_w31", got[31], 3);
    check("t1_last_idx", last_idx, 31);
    burst(0, 0, 0, 0, 0, -1);
    check("t2_count", got.size(), 512);
    check("t2_last_idx", last_idx, 511);
    check("t2_full_rate", last_cyc - first_tv, 511);
    burst(4, 0, 1, 1, 0, -1);
    check("t3_count", got.size(), 32);
    check("t3_w24", got[24], 3);
    burst(100, 10, 0, 0, 0, -1);
    check("clamp_count", got.size(), 512);
    rdy_pct = 50;
    for (int k = 0; k < 6; k++) begin
      int l = $urandom_range(80);
      burst(l, 30, 0, 0, l >= 8, -1);
    end
    burst(6, 0, 0, 1, 1, -1);
    check("t5_count", got.size(), 48);
    rdy_pct = 100;
    burst(8, 0, 0, 0, 0, 6);
    check("t6_truncated", got.size() < 64, 1);
    burst(3, 0, 0, 1, 0, -1);
    check("t6_rearm_count", got.size(), 24);
    check("t6_rearm_w23", got[23], 2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
